// File: rtl/path_delay_pkg.sv
// Shared encodings for the path-delay scheduler: 4-state value codes,
// transition-delay register indices and FSM states.
package path_delay_pkg;

  typedef logic [1:0] val4_t;
  localparam val4_t V0 = 2'b00;
  localparam val4_t V1 = 2'b01;
  localparam val4_t VZ = 2'b10;
  localparam val4_t VX = 2'b11;

  typedef enum logic [2:0] {T01, T10, T0Z, TZ1, T1Z, TZ0} trans_e;

  localparam int DLY_CNT = 6;

  typedef enum logic {S_IDLE, S_WAIT} state_e;

endpackage

// File: rtl/transition_delay_lut.sv
// Combinational lookup of the transition delay for a from->to value change,
// with pessimistic min/max rules for transitions into and out of x.
module transition_delay_lut
  import path_delay_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [1:0]                 from,
  input  logic [1:0]                 to,
  input  logic [DLY_CNT-1:0][DW-1:0] dly,
  output logic [DW-1:0]              d
);

  function automatic logic [DW-1:0] fmin(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [DW-1:0] fmax(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  always_comb begin
    d = '0;
    case ({from, to})
      {V0, V1}: d = dly[int'(T01)];
      {V1, V0}: d = dly[int'(T10)];
      {V0, VZ}: d = dly[int'(T0Z)];
      {VZ, V1}: d = dly[int'(TZ1)];
      {V1, VZ}: d = dly[int'(T1Z)];
      {VZ, V0}: d = dly[int'(TZ0)];
      // entering x takes the earliest possible edge, leaving x the latest
      {V0, VX}: d = fmin(dly[int'(T01)], dly[int'(T0Z)]);
      {V1, VX}: d = fmin(dly[int'(T10)], dly[int'(T1Z)]);
      {VZ, VX}: d = fmin(dly[int'(TZ0)], dly[int'(TZ1)]);
      {VX, V0}: d = fmax(dly[int'(T10)], dly[int'(TZ0)]);
      {VX, V1}: d = fmax(dly[int'(T01)], dly[int'(TZ1)]);
      {VX, VZ}: d = fmax(dly[int'(T0Z)], dly[int'(T1Z)]);
      default:  d = '0;
    endcase
  end

endmodule

// File: rtl/path_delay_scheduler.sv
// Inertial transition-delay emulation: holds a 4-state output and applies a
// new input value only after the programmed delay for that transition.
module path_delay_scheduler
  import path_delay_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_we,
  input  logic [2:0]    cfg_sel,
  input  logic [DW-1:0] cfg_data,
  input  logic [1:0]    in_val,
  output logic [1:0]    out_val,
  output logic          busy,
  output logic          upd,
  output logic          cancel
);

  state_e                 state_q, state_d;
  logic [1:0]             out_q, tgt_q;
  logic [DW-1:0]          cnt_q, lut_d, ld_cnt;
  logic [DLY_CNT-1:0][DW-1:0] dly_q;
  logic                   upd_q, cancel_q;

  transition_delay_lut #(.DW(DW)) u_lut (
    .from (out_q),
    .to   (in_val),
    .dly  (dly_q),
    .d    (lut_d)
  );

  // D=0 is treated as D=1 so there is never a zero-cycle path
  assign ld_cnt = (lut_d == '0) ? '0 : lut_d - DW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (in_val != out_q) state_d = S_WAIT;
      S_WAIT: begin
        if (in_val == out_q)      state_d = S_IDLE;
        else if (in_val != tgt_q) state_d = S_WAIT;
        else if (cnt_q == '0)     state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q    <= V0;
      tgt_q    <= V0;
      cnt_q    <= '0;
      upd_q    <= 1'b0;
      cancel_q <= 1'b0;
      for (int i = 0; i < DLY_CNT; i++) dly_q[i] <= DW'(1);
    end else begin
      upd_q    <= 1'b0;
      cancel_q <= 1'b0;
      // selection above reads dly_q before this write lands
      for (int i = 0; i < DLY_CNT; i++)
        if (cfg_we && cfg_sel == 3'(i)) dly_q[i] <= cfg_data;
      case (state_q)
        S_IDLE: if (in_val != out_q) begin
          tgt_q <= in_val;
          cnt_q <= ld_cnt;
        end
        S_WAIT: begin
          if (in_val == out_q) begin
            cancel_q <= 1'b1;
          end else if (in_val != tgt_q) begin
            tgt_q    <= in_val;
            cnt_q    <= ld_cnt;
            cancel_q <= 1'b1;
          end else if (cnt_q == '0) begin
            out_q <= tgt_q;
            upd_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - DW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy    = (state_q == S_WAIT);
    upd     = upd_q;
    cancel  = cancel_q;
    out_val = out_q;
  end

endmodule

// File: tb/tb_path_delay_scheduler.sv
// Directed bench for path_delay_scheduler: a per-cycle vector table plus
// hand-written sequences for long delays, cancel, reschedule and reset.
module tb_path_delay_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_we = 1'b0;
  logic [2:0] cfg_sel = '0;
  logic [7:0] cfg_data = '0;
  logic [1:0] in_val = 2'b00;
  logic [1:0] out_val;
  logic       busy, upd, cancel;

  int checks = 0;
  int errors = 0;

  path_delay_scheduler #(.DW(8)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_data(cfg_data), .in_val(in_val), .out_val(out_val),
    .busy(busy), .upd(upd), .cancel(cancel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [2:0] sel;
    logic [7:0] data;
    logic [1:0] iv;
    logic [1:0] eo;
    logic       eb, eu, ec;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(input logic we, input logic [2:0] sel, input logic [7:0] data,
                              input logic [1:0] iv, input logic [1:0] eo,
                              input logic eb, input logic eu, input logic ec);
    vec_t v;
    v.we = we; v.sel = sel; v.data = data; v.iv = iv; v.eo = eo;
    v.eb = eb; v.eu = eu; v.ec = ec;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [2:0] sel, input logic [7:0] data);
    cfg_we = 1'b1; cfg_sel = sel; cfg_data = data;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic go(input logic [1:0] v);
    in_val = v;
    step();
  endtask

  // Called right after the edge that scheduled (or rescheduled) a change.
  task automatic run_upd(input string nm, input int d, input logic [1:0] eo);
    int n, bc;
    bc = int'(busy);
    n = 0;
    do begin
      step();
      n++;
      if (!upd) bc += int'(busy);
    end while (!upd && n < d + 20);
    chk({nm, " delay"}, n, d);
    chk({nm, " busy_cycles"}, bc, d);
    chk({nm, " busy_at_upd"}, int'(busy), 0);
    chk({nm, " out_val"}, int'(out_val), int'(eo));
    step();
    chk({nm, " upd_single"}, int'(upd), 0);
  endtask

  initial begin
    int ucnt;
    // row: we sel data in | out busy upd cancel  (all delays start at 1)
    tbl[0]  = mk(0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 2'b01, 2'b00, 1, 0, 0);
    tbl[2]  = mk(0, 0, 0, 2'b01, 2'b01, 0, 1, 0);
    tbl[3]  = mk(0, 0, 0, 2'b01, 2'b01, 0, 0, 0);
    tbl[4]  = mk(0, 0, 0, 2'b10, 2'b01, 1, 0, 0);
    tbl[5]  = mk(0, 0, 0, 2'b10, 2'b10, 0, 1, 0);
    tbl[6]  = mk(0, 0, 0, 2'b11, 2'b10, 1, 0, 0);
    tbl[7]  = mk(0, 0, 0, 2'b10, 2'b10, 0, 0, 1);
    tbl[8]  = mk(1, 6, 0, 2'b10, 2'b10, 0, 0, 0);
    tbl[9]  = mk(1, 0, 3, 2'b10, 2'b10, 0, 0, 0);
    tbl[10] = mk(1, 7, 0, 2'b00, 2'b10, 1, 0, 0);
    tbl[11] = mk(0, 0, 0, 2'b00, 2'b00, 0, 1, 0);
    tbl[12] = mk(0, 0, 0, 2'b01, 2'b00, 1, 0, 0);
    tbl[13] = mk(0, 0, 0, 2'b01, 2'b00, 1, 0, 0);
    tbl[14] = mk(0, 0, 0, 2'b01, 2'b00, 1, 0, 0);
    tbl[15] = mk(0, 0, 0, 2'b01, 2'b01, 0, 1, 0);

    #12;
    chk("reset out_val", int'(out_val), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset upd", int'(upd), 0);
    chk("reset cancel", int'(cancel), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      cfg_we = tbl[i].we; cfg_sel = tbl[i].sel; cfg_data = tbl[i].data;
      in_val = tbl[i].iv;
      step();
      chk($sformatf("vec%0d out_val", i), int'(out_val), int'(tbl[i].eo));
      chk($sformatf("vec%0d busy", i), int'(busy), int'(tbl[i].eb));
      chk($sformatf("vec%0d upd", i), int'(upd), int'(tbl[i].eu));
      chk($sformatf("vec%0d cancel", i), int'(cancel), int'(tbl[i].ec));
    end
    cfg_we = 1'b0;

    // fresh reset, then 0->1 with t01=20
    in_val = 2'b00;
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    wr(3'd0, 8'd20);
    go(2'b01);
    chk("t01 busy_at_k", int'(busy), 1);
    run_upd("t01=20", 20, 2'b01);

    // inertial cancel: 0->1 then back to 0 at cycle 5
    wr(3'd1, 8'd16);
    wr(3'd0, 8'd12);
    go(2'b00);
    run_upd("t10=16", 16, 2'b00);
    go(2'b01);
    repeat (4) step();
    go(2'b00);
    chk("cancel pulse", int'(cancel), 1);
    chk("cancel busy", int'(busy), 0);
    ucnt = 0;
    repeat (15) begin
      step();
      ucnt += int'(upd);
    end
    chk("cancel no_upd", ucnt, 0);
    chk("cancel out_val", int'(out_val), 0);

    // 1->z rescheduled to 1->x at cycle 4
    wr(3'd2, 8'd13);
    wr(3'd4, 8'd14);
    go(2'b01);
    run_upd("t01=12", 12, 2'b01);
    go(2'b10);
    repeat (3) step();
    go(2'b11);
    chk("resched cancel", int'(cancel), 1);
    chk("resched busy", int'(busy), 1);
    run_upd("1->x", 14, 2'b11);

    // x->0 takes max, 0->x takes min
    wr(3'd5, 8'd34);
    go(2'b00);
    run_upd("x->0", 34, 2'b00);
    go(2'b11);
    run_upd("0->x", 12, 2'b11);

    // config write coincident with scheduling uses the old value
    go(2'b00);
    run_upd("x->0 again", 34, 2'b00);
    wr(3'd0, 8'd9);
    cfg_we = 1'b1; cfg_sel = 3'd0; cfg_data = 8'd5;
    in_val = 2'b01;
    step();
    cfg_we = 1'b0;
    run_upd("old t01", 9, 2'b01);
    go(2'b00);
    run_upd("t10 back", 16, 2'b00);
    go(2'b01);
    run_upd("new t01", 5, 2'b01);

    // async reset mid-countdown
    go(2'b00);
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    chk("midrst out_val", int'(out_val), 0);
    chk("midrst busy", int'(busy), 0);
    chk("midrst upd", int'(upd), 0);
    chk("midrst cancel", int'(cancel), 0);
    #2 rst_n = 1'b1;
    step();
    chk("post_rst idle", int'(busy), 0);
    go(2'b01);
    run_upd("rst t01=1", 1, 2'b01);
    go(2'b00);
    run_upd("rst t10=1", 1, 2'b00);
    go(2'b10);
    run_upd("rst t0z=1", 1, 2'b10);
    go(2'b00);
    run_upd("rst tz0=1", 1, 2'b00);

    // D=0 and D=max
    wr(3'd0, 8'd0);
    go(2'b01);
    run_upd("D=0", 1, 2'b01);
    go(2'b00);
    run_upd("back to 0", 1, 2'b00);
    wr(3'd0, 8'd255);
    go(2'b01);
    run_upd("D=255", 255, 2'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
